// File: rtl/ball_controller.sv
// Ball controller for a two-player paddle game on a cell grid.
// The ball moves diagonally one cell per tick period, bouncing off the side
// walls and off the bottom (player 1) and top (player 2) platforms. A missed
// platform scores a point for the opponent, holds the ball for one step and
// then recenters it. The game ends when either score reaches WIN_SCORE.
//
// Ports:
//   clk25MHz           - clock, all logic on the rising edge
//   reset_n            - synchronous active-low reset
//   launch             - single-cycle serve request (honoured only in IDLE)
//   platform1_position - left cell of the bottom platform
//   platform2_position - left cell of the top platform
//   ball_x, ball_y     - ball position
//   ball_state         - 1 while the ball is moving
//   ball_direction     - bit0 = right, bit1 = down
//   score1, score2     - player scores (bottom, top)
//   step_pulse         - one cycle, follows the edge that applied a step
//   point_pulse        - one cycle, follows the edge that incremented a score
//   game_over          - high once the game has ended
module ball_controller #(
  parameter int unsigned FIELD_WIDTH    = 32,
  parameter int unsigned FIELD_HEIGHT   = 24,
  parameter int unsigned PLATFORM_WIDTH = 8,
  parameter int unsigned TICK_DIV       = 12500000,
  parameter int unsigned WIN_SCORE      = 9
) (
  input  logic       clk25MHz,
  input  logic       reset_n,
  input  logic       launch,
  input  logic [5:0] platform1_position,
  input  logic [5:0] platform2_position,
  output logic [5:0] ball_x,
  output logic [4:0] ball_y,
  output logic       ball_state,
  output logic [1:0] ball_direction,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       step_pulse,
  output logic       point_pulse,
  output logic       game_over
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
  localparam logic [5:0] XMax      = 6'(FIELD_WIDTH - 1);
  localparam logic [5:0] XCenter   = 6'(FIELD_WIDTH / 2);
  localparam logic [4:0] YBottom   = 5'(FIELD_HEIGHT - 2);
  localparam logic [4:0] YTop      = 5'd1;
  localparam logic [4:0] YCenter   = 5'(FIELD_HEIGHT / 2);
  localparam logic [3:0] Win       = 4'(WIN_SCORE);
  localparam logic [6:0] PlatSpan  = 7'(PLATFORM_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMove, StMiss, StOver} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      x_q, x_d;
  logic [4:0]      y_q, y_d;
  logic [1:0]      dir_q, dir_d;
  logic [3:0]      s1_q, s1_d, s2_q, s2_d;
  logic            step_q, step_d, point_q, point_d;

  logic       tick;
  logic       cov1, cov2;
  logic [5:0] hx;
  logic       hdir;
  logic [4:0] vy;
  logic       vdir;
  logic       miss;

  assign tick = ((state_q == StMove) || (state_q == StMiss)) && (cnt_q == CntMax);

  // Widened by one bit so pos + PLATFORM_WIDTH - 1 cannot wrap.
  assign cov1 = ({1'b0, x_q} >= {1'b0, platform1_position}) &&
                ({1'b0, x_q} <= ({1'b0, platform1_position} + PlatSpan));
  assign cov2 = ({1'b0, x_q} >= {1'b0, platform2_position}) &&
                ({1'b0, x_q} <= ({1'b0, platform2_position} + PlatSpan));

  // Candidate step; only committed on a MOVE tick.
  always_comb begin
    hx   = x_q;
    hdir = dir_q[0];
    vy   = y_q;
    vdir = dir_q[1];
    miss = 1'b0;
    if (dir_q[0] && (x_q == XMax)) begin
      hdir = 1'b0;
      hx   = x_q - 6'd1;
    end else if (!dir_q[0] && (x_q == 6'd0)) begin
      hdir = 1'b1;
      hx   = x_q + 6'd1;
    end else begin
      hx = dir_q[0] ? x_q + 6'd1 : x_q - 6'd1;
    end
    if (dir_q[1] && (y_q == YBottom)) begin
      if (cov1) begin
        vdir = 1'b0;
        vy   = y_q - 5'd1;
      end else begin
        miss = 1'b1;
      end
    end else if (!dir_q[1] && (y_q == YTop)) begin
      if (cov2) begin
        vdir = 1'b1;
        vy   = y_q + 5'd1;
      end else begin
        miss = 1'b1;
      end
    end else begin
      vy = dir_q[1] ? y_q + 5'd1 : y_q - 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    step_d  = 1'b0;
    point_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (launch) state_d = StMove;
      end
      StMove: begin
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
        if (tick) begin
          step_d = 1'b1;
          if (miss) begin
            // Ball stays put; direction still tells which side missed.
            point_d = 1'b1;
            state_d = StMiss;
            if (dir_q[1]) s2_d = (s2_q == Win) ? s2_q : s2_q + 4'd1;
            else          s1_d = (s1_q == Win) ? s1_q : s1_q + 4'd1;
          end else begin
            x_d   = hx;
            y_d   = vy;
            dir_d = {vdir, hdir};
          end
        end
      end
      StMiss: begin
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
        if (tick) begin
          step_d  = 1'b1;
          x_d     = XCenter;
          y_d     = YCenter;
          dir_d   = dir_q[1] ? 2'b11 : 2'b00;
          state_d = ((s1_q == Win) || (s2_q == Win)) ? StOver : StIdle;
        end
      end
      StOver: begin
        state_d = StOver;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk25MHz) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= XCenter;
      y_q     <= YCenter;
      dir_q   <= 2'b11;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      step_q  <= 1'b0;
      point_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      step_q  <= step_d;
      point_q <= point_d;
    end
  end

  assign ball_x         = x_q;
  assign ball_y         = y_q;
  assign ball_state     = (state_q == StMove);
  assign ball_direction = dir_q;
  assign score1         = s1_q;
  assign score2         = s2_q;
  assign step_pulse     = step_q;
  assign point_pulse    = point_q;
  assign game_over      = (state_q == StOver);

endmodule

// File: tb/tb_ball_controller.sv
// Self-checking bench for ball_controller with TICK_DIV = 4.
// A reference model predicts each step; predictions are queued when the step
// is set up and popped when the DUT raises step_pulse.
module tb_ball_controller;

  localparam int TD = 4;
  localparam int MIdle = 0, MMove = 1, MMiss = 2, MOver = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       launch = 1'b0;
  logic [5:0] p1 = 6'd0, p2 = 6'd0;
  logic [5:0] ball_x;
  logic [4:0] ball_y;
  logic       ball_state;
  logic [1:0] ball_direction;
  logic [3:0] score1, score2;
  logic       step_pulse, point_pulse, game_over;

  ball_controller #(
    .FIELD_WIDTH   (32),
    .FIELD_HEIGHT  (24),
    .PLATFORM_WIDTH(8),
    .TICK_DIV      (TD),
    .WIN_SCORE     (9)
  ) dut (
    .clk25MHz          (clk),
    .reset_n           (rst_n),
    .launch            (launch),
    .platform1_position(p1),
    .platform2_position(p2),
    .ball_x            (ball_x),
    .ball_y            (ball_y),
    .ball_state        (ball_state),
    .ball_direction    (ball_direction),
    .score1            (score1),
    .score2            (score2),
    .step_pulse        (step_pulse),
    .point_pulse       (point_pulse),
    .game_over         (game_over)
  );

  always #20 clk = ~clk;

  typedef struct {
    int x; int y; int dir; int bs; int s1; int s2; int pp; int go;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int mx, my, mdir, ms1, ms2, mst;
  bit corner_seen, wall_seen;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".x"},     32'(ball_x),         e.x);
    check({tag, ".y"},     32'(ball_y),         e.y);
    check({tag, ".dir"},   32'(ball_direction), e.dir);
    check({tag, ".state"}, 32'(ball_state),     e.bs);
    check({tag, ".s1"},    32'(score1),         e.s1);
    check({tag, ".s2"},    32'(score2),         e.s2);
    check({tag, ".point"}, 32'(point_pulse),    e.pp);
    check({tag, ".over"},  32'(game_over),      e.go);
  endtask

  function automatic exp_t snap(input int pp);
    exp_t e;
    e.x = mx; e.y = my; e.dir = mdir; e.bs = (mst == MMove) ? 1 : 0;
    e.s1 = ms1; e.s2 = ms2; e.pp = pp; e.go = (mst == MOver) ? 1 : 0;
    return e;
  endfunction

  function automatic bit covers(input int pos, input int x);
    return (x >= pos) && (x <= pos + 7);
  endfunction

  task automatic model_reset();
    mx = 16; my = 12; mdir = 3; ms1 = 0; ms2 = 0; mst = MIdle;
    sb_q.delete();
  endtask

  task automatic model_step(output int pp);
    int hx, hd, vy, vd;
    bit miss;
    pp = 0;
    if (mst == MMove) begin
      miss = 1'b0;
      hd = mdir & 1;
      vd = mdir >> 1;
      vy = my;
      if (hd == 1 && mx == 31) begin hd = 0; hx = 30; wall_seen = 1'b1; end
      else if (hd == 0 && mx == 0) begin hd = 1; hx = 1; end
      else hx = (hd == 1) ? mx + 1 : mx - 1;
      if (vd == 1 && my == 22) begin
        if (covers(int'(p1), mx)) begin vd = 0; vy = 21; end else miss = 1'b1;
      end else if (vd == 0 && my == 1) begin
        if (covers(int'(p2), mx)) begin vd = 1; vy = 2; end else miss = 1'b1;
      end else vy = (vd == 1) ? my + 1 : my - 1;
      if (!miss && (mx == 0 || mx == 31) && (my == 1 || my == 22)) corner_seen = 1'b1;
      if (miss) begin
        pp = 1;
        mst = MMiss;
        if (vd == 1) ms2 = (ms2 < 9) ? ms2 + 1 : 9;
        else         ms1 = (ms1 < 9) ? ms1 + 1 : 9;
      end else begin
        mx = hx; my = vy; mdir = vd * 2 + hd;
      end
    end else if (mst == MMiss) begin
      mdir = ((mdir >> 1) == 1) ? 3 : 0;
      mx = 16; my = 12;
      mst = (ms1 == 9 || ms2 == 9) ? MOver : MIdle;
    end
  endtask

  // Move a platform under / away from the ball before the step samples it.
  task automatic set_platforms(input bit hit1, input bit hit2);
    if (hit1 && !covers(int'(p1), mx)) p1 = 6'((mx < 24) ? mx : 24);
    if (!hit1 && covers(int'(p1), mx)) p1 = 6'((mx >= 16) ? 0 : 24);
    if (hit2 && !covers(int'(p2), mx)) p2 = 6'((mx < 24) ? mx : 24);
    if (!hit2 && covers(int'(p2), mx)) p2 = 6'((mx >= 16) ? 0 : 24);
  endtask

  task automatic do_step(input string tag, input bit hit1, input bit hit2, output int n);
    exp_t e;
    int pp;
    bit found;
    set_platforms(hit1, hit2);
    model_step(pp);
    sb_q.push_back(snap(pp));
    n = 0;
    found = 1'b0;
    while (n < 2 * TD + 2 && !found) begin
      @(negedge clk);
      n++;
      if (step_pulse === 1'b1) found = 1'b1;
    end
    check({tag, ".step_seen"}, 32'(found), 32'd1);
    e = sb_q.pop_front();
    if (found) check_all(tag, e);
  endtask

  task automatic do_launch();
    @(negedge clk);
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    if (mst == MIdle) mst = MMove;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    launch = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    launch = 1'b0;
    model_reset();
  endtask

  task automatic expect_quiet(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if (step_pulse !== 1'b0) seen = 1'b1;
    end
    check({tag, ".no_step"}, 32'(seen), 32'd0);
    check_all(tag, snap(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t rst_e;
    int n;
    rst_e.x = 16; rst_e.y = 12; rst_e.dir = 3; rst_e.bs = 0;
    rst_e.s1 = 0; rst_e.s2 = 0; rst_e.pp = 0; rst_e.go = 0;
    corner_seen = 1'b0;
    wall_seen = 1'b0;

    // Reset held with launch asserted: reset must win.
    launch = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    launch = 1'b0;
    model_reset();
    check_all("reset", rst_e);
    check("reset.step", 32'(step_pulse), 32'd0);

    // Serve and first-step latency.
    p1 = 6'd20;
    p2 = 6'd0;
    do_launch();
    check("launch.state", 32'(ball_state), 32'd1);
    do_step("step1", 1'b1, 1'b1, lat);
    check("step1.latency", 32'(lat), 32'(TD));
    check("step1.x_const", 32'(ball_x), 32'd17);
    check("step1.y_const", 32'(ball_y), 32'd13);
    @(negedge clk);
    check("step1.pulse_width", 32'(step_pulse), 32'd0);

    for (int i = 2; i <= 10; i++) do_step($sformatf("hit_step%0d", i), 1'b1, 1'b1, n);
    check("step10.x_const", 32'(ball_x), 32'd26);
    check("step10.y_const", 32'(ball_y), 32'd22);
    do_step("bounce11", 1'b1, 1'b1, n);
    check("bounce11.x_const", 32'(ball_x), 32'd27);
    check("bounce11.y_const", 32'(ball_y), 32'd21);
    check("bounce11.dir_const", 32'(ball_direction), 32'd1);

    // Launch while moving is ignored.
    do_launch();
    // Keep rallying until a corner. Positions keep x+y even, so (31,22) is
    // unreachable from the centre; the reachable corner is (31,1).
    for (int i = 0; i < 400 && !corner_seen; i++)
      do_step($sformatf("rally%0d", i), 1'b1, 1'b1, n);
    check("corner_seen", 32'(corner_seen), 32'd1);
    check("wall_seen", 32'(wall_seen), 32'd1);

    // Top miss: score1, then recenter LEFT_UP into IDLE.
    for (int i = 0; i < 80 && mst == MMove; i++)
      do_step($sformatf("topmiss%0d", i), 1'b1, 1'b0, n);
    check("topmiss.s1_const", 32'(score1), 32'd1);
    do_launch();
    do_step("top_recenter", 1'b1, 1'b0, n);
    check("top_recenter.dir_const", 32'(ball_direction), 32'd0);
    expect_quiet("top_idle");

    // Nine bottom misses end the game.
    apply_reset();
    check_all("reset2", rst_e);
    for (int r = 1; r <= 9; r++) begin
      do_launch();
      for (int s = 1; s <= 12; s++)
        do_step($sformatf("r%0d_s%0d", r, s), 1'b0, 1'b1, n);
    end
    check("over.s2_const", 32'(score2), 32'd9);
    check("over.go_const", 32'(game_over), 32'd1);
    do_launch();
    expect_quiet("over_launch");

    // Reset in the middle of MISS.
    apply_reset();
    do_launch();
    for (int s = 1; s <= 11; s++) do_step($sformatf("m_s%0d", s), 1'b0, 1'b1, n);
    check("miss.s2_const", 32'(score2), 32'd1);
    rst_n = 1'b0;
    launch = 1'b1;
    @(negedge clk);
    check_all("miss_reset", rst_e);
    check("miss_reset.step", 32'(step_pulse), 32'd0);
    rst_n = 1'b1;
    launch = 1'b0;
    model_reset();
    expect_quiet("after_miss_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
